// File: rtl/audio_nios_cpu_mult_seq.sv
// -----------------------------------------------------------------------------
// audio_nios_cpu_mult_seq
// Iterative multiplier for the Nios CPU A-stage. Builds the full 2*DATA_W-bit
// product of src1 x src2 from sign-free magnitudes, consuming one SLICE_W-bit
// slice of src2 per MUL cycle. The sign is reapplied in a FIX cycle, and either
// the low half (mul) or the high half (mulxss/mulxsu/mulxuu) is returned.
//
// Ports
//   clk      in   1       rising-edge clock
//   reset_n  in   1       asynchronous active-low reset
//   start    in   1       request, sampled only while idle
//   flush    in   1       abort the in-flight op; no done is produced
//   op       in   2       00 mul, 01 mulxss, 10 mulxsu, 11 mulxuu
//   src1     in   DATA_W  multiplicand
//   src2     in   DATA_W  multiplier
//   busy     out  1       high while an op is in flight
//   done     out  1       one-cycle pulse, result valid
//   result   out  DATA_W  selected product half, held until the next done
// -----------------------------------------------------------------------------
module audio_nios_cpu_mult_seq #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              flush,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int N      = DATA_W / SLICE_W;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W  = 2 * DATA_W;
  localparam int PROD_W = DATA_W + SLICE_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e              state_q;
  logic [1:0]          op_q;
  logic                neg_q;
  logic [DATA_W-1:0]   mag_a_q;
  logic [DATA_W-1:0]   mag_b_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   result_q;

  logic                sign_a;
  logic                sign_b;
  logic [DATA_W-1:0]   src1_mag;
  logic [DATA_W-1:0]   src2_mag;
  logic [PROD_W-1:0]   prod;
  logic [ACC_W-1:0]    pp;
  logic [ACC_W-1:0]    p;

  always_comb begin
    // Only mulxss/mulxsu treat src1 as signed; only mulxss treats src2 as signed.
    sign_a   = src1[DATA_W-1] & ((op == 2'b01) | (op == 2'b10));
    sign_b   = src2[DATA_W-1] & (op == 2'b01);
    // Unsigned negation maps the most negative value onto 2^(DATA_W-1) exactly.
    src1_mag = sign_a ? (~src1 + 1'b1) : src1;
    src2_mag = sign_b ? (~src2 + 1'b1) : src2;
    // mag_b_q shifts right each MUL cycle, so its low slice is always the
    // current one; the partial product is realigned by the slice index.
    prod     = PROD_W'(mag_a_q) * PROD_W'(mag_b_q[SLICE_W-1:0]);
    pp       = ACC_W'(prod) << (int'(cnt_q) * SLICE_W);
    p        = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      neg_q    <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A simultaneous flush suppresses the capture entirely.
          if (start && !flush) begin
            op_q    <= op;
            neg_q   <= sign_a ^ sign_b;
            mag_a_q <= src1_mag;
            mag_b_q <= src2_mag;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_MUL;
            busy_q  <= 1'b1;
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q   <= acc_q + pp;
            mag_b_q <= mag_b_q >> SLICE_W;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            result_q <= (op_q == 2'b00) ? p[DATA_W-1:0] : p[ACC_W-1:DATA_W];
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_audio_nios_cpu_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_audio_nios_cpu_mult_seq
// Directed and randomized bench for the iterative multiplier. Two instances are
// exercised: the default 32/16 configuration and a 24/8 configuration. Expected
// results come from a plain modular-arithmetic product of the extended operands.
// -----------------------------------------------------------------------------
module tb_audio_nios_cpu_mult_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;

  logic        start_a = 1'b0, flush_a = 1'b0;
  logic [1:0]  op_a = 2'b00;
  logic [31:0] src1_a = '0, src2_a = '0;
  logic        busy_a, done_a;
  logic [31:0] result_a;

  logic        start_b = 1'b0, flush_b = 1'b0;
  logic [1:0]  op_b = 2'b00;
  logic [23:0] src1_b = '0, src2_b = '0;
  logic        busy_b, done_b;
  logic [23:0] result_b;

  int checks = 0;
  int errors = 0;

  audio_nios_cpu_mult_seq #(.DATA_W(32), .SLICE_W(16)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .flush(flush_a), .op(op_a),
    .src1(src1_a), .src2(src2_a), .busy(busy_a), .done(done_a), .result(result_a)
  );

  audio_nios_cpu_mult_seq #(.DATA_W(24), .SLICE_W(8)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .flush(flush_b), .op(op_b),
    .src1(src1_b), .src2(src2_b), .busy(busy_b), .done(done_b), .result(result_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: extend each operand to 64 bits per the op's signedness, multiply
  // modulo 2^64 and pick the requested w-bit half.
  function automatic logic [31:0] ref_mul(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ea, eb, prd;
    logic        sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ea   = {32'd0, a} & mask;
    eb   = {32'd0, b} & mask;
    sa   = ((op == 2'b01) || (op == 2'b10)) && ea[w-1];
    sb   = (op == 2'b01) && eb[w-1];
    if (sa) ea = ea | ~mask;
    if (sb) eb = eb | ~mask;
    prd  = ea * eb;
    if (op == 2'b00) return 32'(prd & mask);
    return 32'((prd >> w) & mask);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0080_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic cur_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  function automatic logic [31:0] cur_result(input bit sel);
    return sel ? {8'd0, result_b} : result_a;
  endfunction

  // Issue one op on the selected instance and check latency and result.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string tag);
    int  lat;
    bit  seen;
    if (!sel) begin
      op_a = op; src1_a = a; src2_a = b; start_a = 1'b1;
    end else begin
      op_b = op; src1_b = a[23:0]; src2_b = b[23:0]; start_b = 1'b1;
    end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      lat = i;
      if (cur_done(sel)) seen = 1'b1;
    end
    check({tag, "_lat"}, lat, sel ? 4 : 3);
    check({tag, "_res"}, cur_result(sel), exp);
  endtask

  initial begin
    int          ndone;
    int          lat;
    bit          seen;
    logic [31:0] held;
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    // Asynchronous reset, checked before any clock edge can intervene.
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_result", result_a, 32'd0);
    check("rst_busy_b", busy_b, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Basic mul with busy profile and single-cycle done.
    op_a = 2'b00; src1_a = 32'h0001_0003; src2_a = 32'h0000_0005; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t1_busy1", busy_a, 1'b1);
    check("t1_done1", done_a, 1'b0);
    tick();
    check("t1_busy2", busy_a, 1'b1);
    check("t1_done2", done_a, 1'b0);
    tick();
    check("t1_busy3", busy_a, 1'b1);
    check("t1_done3", done_a, 1'b0);
    tick();
    check("t1_busy4", busy_a, 1'b0);
    check("t1_done4", done_a, 1'b1);
    check("t1_res", result_a, 32'h0005_000F);
    tick();
    check("t1_done_pulse", done_a, 1'b0);
    check("t1_res_held", result_a, 32'h0005_000F);

    // Sign handling corners.
    run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "t2_xss");
    run_op(1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "t2_xuu");
    run_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "t2_mul");
    run_op(1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "t3_xss_min");
    run_op(1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "t3_xsu");

    // start pulsed while busy is ignored.
    op_a = 2'b00; src1_a = 32'd3; src2_a = 32'd5; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    src1_a = 32'd7; src2_a = 32'd7; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_a) ndone++;
      tick();
    end
    check("t4_ignored_cnt", ndone, 1);
    check("t4_ignored_res", result_a, 32'd15);

    // start held high through the done cycle: a second op is accepted there.
    op_a = 2'b00; src1_a = 32'd2; src2_a = 32'd3; start_a = 1'b1;
    tick();
    src1_a = 32'd4; src2_a = 32'd5;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done_a) seen = 1'b1;
    end
    check("t4_held_first_seen", seen, 1'b1);
    check("t4_held_first_res", result_a, 32'd6);
    tick();
    start_a = 1'b0;
    check("t4_held_accept_busy", busy_a, 1'b1);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      lat = i;
      if (done_a) seen = 1'b1;
    end
    check("t4_held_second_lat", lat, 3);
    check("t4_held_second_res", result_a, 32'd20);

    // Flush one cycle after accept: no done, result retained.
    held = result_a;
    op_a = 2'b11; src1_a = 32'h1234_5678; src2_a = 32'h9ABC_DEF0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("t5_flush_busy", busy_a, 1'b0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_a) ndone++;
      tick();
    end
    check("t5_flush_nodone", ndone, 0);
    check("t5_flush_res", result_a, held);

    // flush and start together while idle: nothing captured.
    start_a = 1'b1;
    flush_a = 1'b1;
    tick();
    start_a = 1'b0;
    flush_a = 1'b0;
    check("t5_flush_start_busy", busy_a, 1'b0);
    tick();
    check("t5_flush_start_nodone", done_a, 1'b0);

    // Reset mid-MUL clears outputs without waiting for a clock edge.
    op_a = 2'b00; src1_a = 32'd9; src2_a = 32'd9; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t5_pre_rst_res_nonzero", result_a != 32'd0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy_a, 1'b0);
    check("t5_rst_done", done_a, 1'b0);
    check("t5_rst_res", result_a, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t5_rst_idle", busy_a, 1'b0);

    // Random ops on the 32/16 instance.
    for (int i = 0; i < 40; i++) begin
      ra  = pick();
      rb  = pick();
      rop = 2'($urandom_range(0, 3));
      run_op(1'b0, rop, ra, rb, ref_mul(32, rop, ra, rb), $sformatf("rnd_a%0d", i));
    end

    // 24/8 instance: directed corner then random ops.
    run_op(1'b1, 2'b11, 32'h00FF_FFFF, 32'h00FF_FFFF, 32'h00FF_FFFE, "t6_xuu24");
    run_op(1'b1, 2'b01, 32'h0080_0000, 32'h0080_0000, 32'h0040_0000, "t6_xss24_min");
    for (int i = 0; i < 30; i++) begin
      ra  = pick();
      rb  = pick();
      rop = 2'($urandom_range(0, 3));
      run_op(1'b1, rop, ra, rb, ref_mul(24, rop, ra, rb), $sformatf("rnd_b%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
